// File: rtl/adpll_tdc_pkg.sv
// Shared TDC front-end definitions: default widths, FSM encoding
// and the Gray / thermometer helper functions.
package adpll_tdc_pkg;

   localparam int TDC_CNTW   = 7;
   localparam int TDC_NTAPS  = 16;
   localparam int TDC_WARMUP = 8;
   localparam int TDC_ERRW   = 8;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } tdc_state_e;

   // Helpers work on 32-bit containers; callers zero-extend and
   // truncate, which is exact for any width up to 32.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < 32; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   // Ones contiguous from the LSB (all-0 and all-1 included).
   function automatic logic is_therm(input logic [31:0] t);
      return ((t & (t + 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/tdc_gray_counter.sv
// ckv-domain edge counter: power-down synchronizer, binary counter
// and the registered Gray copy that is the only signal leaving ckv.
module tdc_gray_counter
   import adpll_tdc_pkg::*;
#(
   parameter int CNTW = TDC_CNTW
) (
   input  logic            ckv_i,
   input  logic            rst_i,
   input  logic            tdc_pd_i,
   output logic [CNTW-1:0] gray_o
);

   logic            pd_s1_q;
   logic            pd_ckv_q;
   logic [CNTW-1:0] bin_q;
   logic [CNTW-1:0] bin_d;
   logic [CNTW-1:0] gray_q;

   // Bring the FREF-domain power-down into ckv.
   always_ff @(posedge ckv_i or posedge rst_i) begin
      if (rst_i) begin
         pd_s1_q  <= 1'b0;
         pd_ckv_q <= 1'b0;
      end else begin
         pd_s1_q  <= tdc_pd_i;
         pd_ckv_q <= pd_s1_q;
      end
   end

   // Counter held at zero while powered down, else free-running.
   always_comb begin
      bin_d = pd_ckv_q ? '0 : bin_q + CNTW'(1);
   end

   // Gray copy tracks the same edge as the binary count.
   always_ff @(posedge ckv_i or posedge rst_i) begin
      if (rst_i) begin
         bin_q  <= '0;
         gray_q <= '0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= CNTW'(bin2gray(32'(bin_d)));
      end
   end

   assign gray_o = gray_q;

endmodule

// File: rtl/tdc_front_end.sv
// TDC digital front end: Gray count capture, tap bubble correction,
// power-up sequencing FSM and bubble error statistics.
module tdc_front_end
   import adpll_tdc_pkg::*;
#(
   parameter int CNTW   = TDC_CNTW,
   parameter int NTAPS  = TDC_NTAPS,
   parameter int WARMUP = TDC_WARMUP,
   parameter int ERRW   = TDC_ERRW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ckv,
   input  logic             en,
   input  logic             tdc_pd,
   input  logic [NTAPS-1:0] taps,
   output logic [CNTW-1:0]  tdc_ripple_count,
   output logic [NTAPS-1:0] tdc_phase,
   output logic             tdc_valid,
   output logic [ERRW-1:0]  bubble_err_count
);

   localparam int WCW = $clog2(WARMUP) + 1;

   logic [CNTW-1:0]  gray_ckv;
   logic [CNTW-1:0]  g1_q;
   logic [CNTW-1:0]  g2_q;
   logic [NTAPS-1:0] t1_q;
   logic [NTAPS-1:0] t2_q;
   logic [NTAPS+1:0] ext;
   logic [NTAPS-1:0] corr;
   logic             therm_ok;

   tdc_state_e       state_q;
   tdc_state_e       state_d;
   logic [WCW-1:0]   wcnt_q;
   logic [WCW-1:0]   wcnt_d;

   logic             out_clr;
   logic             err_inc;
   logic [CNTW-1:0]  cnt_q;
   logic [NTAPS-1:0] ph_q;
   logic [ERRW-1:0]  err_q;

   tdc_gray_counter #(
      .CNTW(CNTW)
   ) u_cnt (
      .ckv_i   (ckv),
      .rst_i   (rst),
      .tdc_pd_i(tdc_pd),
      .gray_o  (gray_ckv)
   );

   // Two-stage capture of the Gray count and the raw taps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g1_q <= '0;
         g2_q <= '0;
         t1_q <= '0;
         t2_q <= '0;
      end else if (en) begin
         g1_q <= gray_ckv;
         g2_q <= g1_q;
         t1_q <= taps;
         t2_q <= t1_q;
      end
   end

   // Three-tap majority vote with a 1 below bit 0 and a 0 above.
   always_comb begin
      ext  = {1'b0, t2_q, 1'b1};
      corr = '0;
      for (int i = 0; i < NTAPS; i++) begin
         corr[i] = (ext[i] & ext[i+1]) |
                   (ext[i] & ext[i+2]) |
                   (ext[i+1] & ext[i+2]);
      end
      therm_ok = is_therm(32'(t2_q));
   end

   // FSM state and warm-up counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OFF;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Next state: power-down beats every other transition.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      if (en) begin
         if (tdc_pd) begin
            state_d = ST_OFF;
            wcnt_d  = '0;
         end else begin
            unique case (state_q)
               ST_OFF: begin
                  state_d = ST_WARMUP;
                  wcnt_d  = '0;
               end
               ST_WARMUP: begin
                  if (wcnt_q == WCW'(WARMUP - 1)) begin
                     state_d = ST_RUN;
                  end else begin
                     wcnt_d = wcnt_q + WCW'(1);
                  end
               end
               ST_RUN: begin
                  state_d = ST_RUN;
               end
               default: begin
                  state_d = ST_OFF;
                  wcnt_d  = '0;
               end
            endcase
         end
      end
   end

   // FSM outputs: valid flag, output clear, error count enable.
   always_comb begin
      tdc_valid = (state_q == ST_RUN);
      out_clr   = (state_d == ST_OFF);
      err_inc   = (state_d == ST_RUN) && !therm_ok;
   end

   // Output registers; count and phase from the same capture edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ph_q  <= '0;
      end else if (en) begin
         if (out_clr) begin
            cnt_q <= '0;
            ph_q  <= '0;
         end else begin
            cnt_q <= CNTW'(gray2bin(32'(g2_q)));
            ph_q  <= corr;
         end
      end
   end

   // Saturating count of non-thermometer samples seen in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
      end else if (en && err_inc && (err_q != '1)) begin
         err_q <= err_q + ERRW'(1);
      end
   end

   assign tdc_ripple_count = cnt_q;
   assign tdc_phase        = ph_q;
   assign bubble_err_count = err_q;

endmodule

// File: tb/tb_tdc_front_end.sv
// Scoreboard bench for tdc_front_end: ckv runs at exactly 10x FREF,
// expected samples are queued by the stimulus and checked on valid.
module tb_tdc_front_end;

   typedef struct {
      logic [6:0]  c;
      logic [15:0] ph;
      logic [7:0]  err;
   } exp_t;

   typedef struct {
      logic [6:0] c;
      int         idx;
   } smp_t;

   logic        clk = 1'b0;
   logic        ckv = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        tdc_pd = 1'b1;
   logic [15:0] taps = '0;
   logic [6:0]  tdc_ripple_count;
   logic [15:0] tdc_phase;
   logic        tdc_valid;
   logic [7:0]  bubble_err_count;

   int n_chk = 0;
   int n_fail = 0;

   // taps vector, corrected phase, bubble flag
   logic [15:0] tv [0:9] = '{16'h0000, 16'h00FF, 16'hFFFF,
      16'h00FB, 16'h0100, 16'h0003, 16'h0005, 16'h7FFF,
      16'hFFFE, 16'h0FF7};
   logic [15:0] pv [0:9] = '{16'h0000, 16'h00FF, 16'hFFFF,
      16'h00FF, 16'h0000, 16'h0003, 16'h0003, 16'h7FFF,
      16'hFFFF, 16'h0FFF};
   bit bv [0:9] = '{0, 0, 0, 1, 1, 0, 1, 0, 1, 1};

   exp_t exp_q [$];
   smp_t smp [$];
   exp_t cur;
   int   ne = 0;
   int   k_fall = 0;
   bit   pd_hi = 1'b1;
   bit   last_pd = 1'b1;
   logic [7:0] err_m = '0;

   tdc_front_end dut (
      .clk             (clk),
      .rst             (rst),
      .ckv             (ckv),
      .en              (en),
      .tdc_pd          (tdc_pd),
      .taps            (taps),
      .tdc_ripple_count(tdc_ripple_count),
      .tdc_phase       (tdc_phase),
      .tdc_valid       (tdc_valid),
      .bubble_err_count(bubble_err_count)
   );

   initial forever #50 clk = ~clk;

   initial begin
      #2;
      forever #5 ckv = ~ckv;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Monitor: every valid output pops one expected sample.
   always @(negedge clk) begin
      exp_t e;
      if (tdc_valid === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid cnt=%0d ph=%h",
                     tdc_ripple_count, tdc_phase);
         end else begin
            e = exp_q.pop_front();
            if (tdc_ripple_count !== e.c ||
                tdc_phase !== e.ph ||
                bubble_err_count !== e.err) begin
               n_fail++;
               $display("FAIL sample t=%0t cnt=%0d want %0d ph=%h want %h err=%0d want %0d",
                        $time, tdc_ripple_count, e.c, tdc_phase,
                        e.ph, bubble_err_count, e.err);
            end
         end
      end
   end

   task automatic chk_off(input string nm);
      n_chk++;
      if (tdc_valid !== 1'b0 || tdc_ripple_count !== 7'd0 ||
          tdc_phase !== 16'd0) begin
         n_fail++;
         $display("FAIL %s t=%0t valid=%b cnt=%0d ph=%h want 0",
                  nm, $time, tdc_valid, tdc_ripple_count,
                  tdc_phase);
      end
   endtask

   task automatic chk_err(input string nm, input logic [7:0] w);
      n_chk++;
      if (bubble_err_count !== w) begin
         n_fail++;
         $display("FAIL %s err=%0d want %0d",
                  nm, bubble_err_count, w);
      end
   endtask

   // One FREF cycle: drive at negedge, model the following posedge.
   task automatic tick(input bit pd, input bit e, input int idx);
      smp_t s;
      smp_t o;
      bit   vld;
      @(negedge clk);
      if (last_pd) chk_off("pd_off");
      tdc_pd = pd;
      en     = e;
      taps   = tv[idx];
      if (pd) begin
         pd_hi = 1'b1;
      end else if (pd_hi) begin
         pd_hi  = 1'b0;
         k_fall = ne;
      end
      vld = !pd_hi && (ne >= k_fall + 8);
      if (e) begin
         s.c   = pd_hi ? 7'd0 : 7'((3 + 10 * (ne - k_fall)) % 128);
         s.idx = idx;
         smp.push_back(s);
         if (smp.size() > 2) begin
            o = smp.pop_front();
            if (vld) begin
               if (bv[o.idx] && err_m != 8'hFF) err_m = err_m + 8'd1;
               cur.c   = o.c;
               cur.ph  = pv[o.idx];
               cur.err = err_m;
               exp_q.push_back(cur);
            end
         end
      end else if (vld) begin
         exp_q.push_back(cur);
      end
      last_pd = pd;
      ne++;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_off("reset");
      chk_err("reset_err", 8'd0);
      rst = 1'b0;

      repeat (50) tick(1'b1, 1'b1, 0);
      chk_err("pd_err", 8'd0);

      for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, i % 10);

      repeat (3) tick(1'b1, 1'b1, 1);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, i % 10);

      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, i % 10);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, (i + 3) % 10);

      repeat (300) tick(1'b0, 1'b1, 3);
      tick(1'b0, 1'b1, 1);
      chk_err("err_sat", 8'hFF);
      repeat (2) tick(1'b0, 1'b1, 6);
      chk_err("err_hold", 8'hFF);

      @(negedge clk);
      tdc_pd = 1'b1;
      #10 rst = 1'b1;
      #1;
      chk_off("async_rst");
      chk_err("async_rst_err", 8'd0);
      #10 rst = 1'b0;
      pd_hi   = 1'b1;
      last_pd = 1'b1;
      err_m   = '0;
      smp.delete();
      ne++;

      repeat (10) tick(1'b1, 1'b1, 0);
      for (int i = 0; i < 14; i++) tick(1'b0, 1'b1, 9 - (i % 10));
      repeat (2) tick(1'b1, 1'b1, 0);
      #1;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain left=%0d want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tdc_front_end.md
# tdc_front_end

Digital front end of the time-to-digital converter: counts DCO (ckv) edges in a free-running Gray-coded ripple counter and samples the analog delay-line taps on each FREF edge. It delivers an aligned, bubble-corrected `tdc_ripple_count`/`tdc_phase` pair to the ADPLL controller's TDC interface. It sits between the analog TDC macro and the controller, and owns the ckv→FREF clock-domain crossing and TDC power-up sequencing.

## Interface
- `CNTW`, 7: ripple counter width (must match controller `tdc_ripple_count`).
- `NTAPS`, 16: delay-line taps (must match controller `tdc_phase`).
- `WARMUP`, 8: FREF cycles after power-up before output is valid.
- `ERRW`, 8: bubble error counter width.

Ports:
- `clk` in 1: FREF clock; all outputs are in this domain.
- `rst` in 1: reset, asynchronous, active-high.
- `ckv` in 1: DCO-derived clock being measured.
- `en` in 1: FREF-domain enable; 0 freezes all FREF-domain registers.
- `tdc_pd` in 1: TDC power-down from the controller (FREF domain).
- `taps` in NTAPS: raw delay-line thermometer, asynchronous to clk.
- `tdc_ripple_count` out CNTW: ckv edge count sampled at FREF.
- `tdc_phase` out NTAPS: corrected thermometer phase.
- `tdc_valid` out 1: outputs meaningful (FSM in RUN).
- `bubble_err_count` out ERRW: saturating count of non-thermometer samples.

## Operation
- ckv domain: 2-flop synchronizer of `tdc_pd` feeds `pd_ckv`. A binary counter `bin` increments on each posedge `ckv`, and is forced to 0 while `rst` or `pd_ckv`. A registered Gray copy, `gray = bin ^ (bin>>1)`, is updated on the same edge. Only `gray` crosses domains.
- FREF capture, posedge clk: `g1 <= gray`, `g2 <= g1`, `t1 <= taps`, `t2 <= t1`. Gray sampling guarantees at most ±1 LSB capture uncertainty, never a torn value.
- Output stage: `tdc_ripple_count <= gray2bin(g2)` and `tdc_phase <= correct(t2)`.
- Wrap: the count rolls over at 2^CNTW-1 → 0. The consumer differences modulo 2^CNTW. No saturation.
- Bubble correction: each output bit i is the majority of (t2[i-1], t2[i], t2[i+1]), with t2[-1]=1 and t2[NTAPS]=0.
- Bubble errors: if t2 is not a valid thermometer (ones contiguous from the LSB, including all-0 and all-1), `bubble_err_count` increments. It saturates at 2^ERRW-1 and counts only in RUN.
- FSM (FREF domain), states OFF, WARMUP, RUN:
  - OFF: entered on reset or `tdc_pd`=1. Outputs are forced to 0 and `wcnt`=0.
  - OFF→WARMUP: on `tdc_pd`=0. `wcnt` increments each enabled cycle.
  - WARMUP→RUN: when `wcnt`==WARMUP-1.
  - RUN: `tdc_valid`=1.
  - Any state→OFF: on the cycle after `tdc_pd` rises. This has priority over everything else.
- `en`=0: FSM, pipeline, outputs and error counter hold. The ckv counter keeps running.
- Reset values: `tdc_ripple_count`=0, `tdc_phase`=0, `tdc_valid`=0, `bubble_err_count`=0, state=OFF. The ckv counter and synchronizers also clear.

## Timing
- Latency: the ckv count and taps present at posedge clk k appear on the outputs after posedge k+2. Count and phase are always from the same sample edge.
- Outputs change only on posedge clk. The controller samples them on negedge, giving a half-cycle setup margin.
- `tdc_pd` 1→0 at edge k: state is WARMUP after k. `tdc_valid`=1 after edge k+WARMUP. The first valid count reflects a counter released ≤3 ckv cycles after the pd fall.
- `tdc_pd` 0→1 at edge k: `tdc_valid`=0 and outputs are 0 after edge k.
- Simultaneous `tdc_pd` rise and WARMUP completion: OFF wins.
- Async `rst` mid-operation: all outputs clear immediately. Operation resumes from OFF on release.

## Structure
- Shared package `adpll_tdc_pkg`: CNTW, NTAPS, WARMUP defaults, FSM state encoding, `bin2gray`/`gray2bin` functions and the thermometer-validity function.
- Sub-module `tdc_gray_counter`: ckv domain only, containing the pd synchronizer, binary counter and Gray register. The top level holds the capture pipeline, correction, FSM and error counter.

## Test plan
- Reset/power-down: assert `rst`, then hold `tdc_pd`=1 for 50 FREF cycles with ckv running → all outputs 0 and `tdc_valid`=0 throughout.
- Warm-up: set ckv = 10×FREF exactly, drop `tdc_pd` at edge 0 → `tdc_valid` rises after edge 8, and consecutive valid counts differ by exactly 10 mod 128.
- Wrap: same ratio, run past 127 → e.g. 120 followed by 2, with no glitch value in between.
- Bubble: `taps`=16'h00FF → `tdc_phase`=16'h00FF and the error count is unchanged. `taps`=16'h00FB → `tdc_phase`=16'h00FF and the error count +1. After 300 bubbled samples → `bubble_err_count`=255 and it holds there.
- Power-down mid-RUN: raise `tdc_pd` → `tdc_valid`=0 and outputs 0 on the next edge. Lower it again → valid returns after 8 cycles. Also drive `en`=0 for 5 cycles → outputs frozen.
- Async reset mid-RUN: pulse `rst` between clk edges → outputs 0 immediately. After release the block stays OFF until `tdc_pd`=0.
